fetch_queue: RTL
================

# fetch_queue

Instruction fetch stage with a small prefetch queue, sitting directly upstream of the opcode/operand pipeline registers that feed the register-read (R) stage. It owns the program counter, drives the program-memory address, and buffers fetched {opcode, operand, next-PC} triples. It accepts stalls from the R stage and redirects (taken jump/call/return) from the execute-stage control, flushing on redirect.

## Interface
Parameters:
- DEPTH, 4: queue entries (power of two, 2..8)
- AW, 8: program address / PC width
- DW, 8: opcode and operand width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- pm_addr  out  AW  program-memory address (= PC register)
- pm_opcode  in  DW  program-memory opcode at pm_addr, combinational, same cycle
- pm_operand  in  DW  program-memory operand at pm_addr, combinational, same cycle
- redirect  in  1  load PC and flush queue
- redirect_addr  in  AW  new PC when redirect=1
- stall  in  1  R stage cannot accept the head entry this cycle
- valid_out  out  1  head entry valid
- oc_out  out  DW  head opcode
- or_out  out  DW  head operand
- npc_out  out  AW  head instruction address + 1 (mod 2^AW)
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State: PC register, DEPTH-entry storage, read pointer, write pointer, occupancy counter.
- pop = valid_out & ~stall.
- fetch = ~redirect & (count < DEPTH | pop).
- On fetch: write {pm_opcode, pm_operand, PC+1} at write pointer; PC <= PC+1; write pointer advances.
- On pop: read pointer advances.
- count next = count + fetch − pop; push and pop in the same cycle leave count unchanged.
- Full (count==DEPTH) with no pop: no fetch, PC and pm_addr hold.
- Empty: valid_out=0; pop cannot occur whatever stall is.
- Redirect (highest priority after rst): count <= 0, both pointers <= 0, PC <= redirect_addr; no push and no pop take effect that cycle, regardless of stall.
- valid_out = (count != 0). oc_out/or_out/npc_out show the entry at read pointer when valid_out=1 and are forced to 0 when valid_out=0.
- Arithmetic: PC and npc wrap modulo 2^AW (0xFF+1 = 0x00); pointers wrap modulo DEPTH.
- Reset: PC=0, pointers=0, count=0. Outputs: pm_addr=0, valid_out=0, oc_out=0, or_out=0, npc_out=0, count=0. Storage contents undefined, never observable.

## Timing
- pm_addr is registered. Program memory is combinational, so the fetch for pm_addr completes in the same cycle.
- Fetch-to-output latency is 1 cycle. An instruction fetched in cycle t is at the head (if the queue was empty) in cycle t+1.
- Redirect asserted in cycle t:
  - cycle t+1: pm_addr = redirect_addr, valid_out = 0
  - cycle t+2: valid_out = 1 with npc_out = redirect_addr+1
- Stall is sampled each cycle. The head stays stable while stall=1.
- rst is honoured asynchronously mid-operation. Deassertion is synchronous to clk, and the first fetch occurs on the first clock edge after deassertion.
- Steady state with stall=0: one instruction per cycle; count settles at 1.

## Test plan
- Reset then free-run: PM[n] = {opcode n, operand n+0x80}, stall=0. Required: pm_addr steps 0,1,2,…; cycle 1 after reset shows valid_out=1, oc_out=0x00, or_out=0x80, npc_out=0x01; count stays 1.
- Stall held from reset: pm_addr stops at 0x04 with count=4. Release stall: heads 0x00,0x01,0x02,0x03,0x04… appear in order with no gaps or duplicates.
- Full plus pop: at count=4, stall pulses low for one cycle. Required: exactly one fetch, count remains 4, pm_addr advances by exactly 1.
- Redirect while full, redirect_addr=0x40, stall=1. Required: next cycle count=0, valid_out=0, pm_addr=0x40; the following cycle valid_out=1 with npc_out=0x41.
- Wrap: redirect to 0xFF, stall=0. Required: pm_addr sequence 0xFF,0x00,0x01; the 0xFF entry shows npc_out=0x00.
- Asynchronous reset asserted mid-cycle with count=3. Required: immediately valid_out=0, count=0, pm_addr=0x00, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, drives program memory, and buffers
// fetched {opcode, operand, next-PC} entries for the register-read stage.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [AW-1:0]              pm_addr,
    input  logic [DW-1:0]              pm_opcode,
    input  logic [DW-1:0]              pm_operand,
    input  logic                       redirect,
    input  logic [AW-1:0]              redirect_addr,
    input  logic                       stall,
    output logic                       valid_out,
    output logic [DW-1:0]              oc_out,
    output logic [DW-1:0]              or_out,
    output logic [AW-1:0]              npc_out,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [DW-1:0] oc_mem_q  [DEPTH];
    logic [DW-1:0] oc_mem_d  [DEPTH];
    logic [DW-1:0] or_mem_q  [DEPTH];
    logic [DW-1:0] or_mem_d  [DEPTH];
    logic [AW-1:0] npc_mem_q [DEPTH];
    logic [AW-1:0] npc_mem_d [DEPTH];

    logic valid;
    logic pop;
    logic fetch;

    assign valid = (count_q != '0);
    assign pop   = valid & ~stall;
    // A pop frees a slot in the same cycle, so a full queue still fetches.
    assign fetch = ~redirect & ((count_q < CW'(DEPTH)) | pop);

    always_comb begin
        pc_d      = pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        oc_mem_d  = oc_mem_q;
        or_mem_d  = or_mem_q;
        npc_mem_d = npc_mem_q;
        if (redirect) begin
            pc_d     = redirect_addr;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fetch) begin
                oc_mem_d[wr_ptr_q]  = pm_opcode;
                or_mem_d[wr_ptr_q]  = pm_operand;
                npc_mem_d[wr_ptr_q] = pc_q + 1'b1;
                pc_d                = pc_q + 1'b1;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(fetch) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never visible while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        oc_mem_q  <= oc_mem_d;
        or_mem_q  <= or_mem_d;
        npc_mem_q <= npc_mem_d;
    end

    assign pm_addr   = pc_q;
    assign count     = count_q;
    assign valid_out = valid;
    assign oc_out    = valid ? oc_mem_q[rd_ptr_q]  : '0;
    assign or_out    = valid ? or_mem_q[rd_ptr_q]  : '0;
    assign npc_out   = valid ? npc_mem_q[rd_ptr_q] : '0;

endmodule
